// File: rtl/lb_frame_sequencer_if.sv
// Pixel-source handshake and memory-core bus seen by the line-buffer frame sequencer.
// master = sequencer side, slave = pixel source / memory core side.
interface lb_frame_sequencer_if #(
  parameter int DW = 16
);
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;

  logic          mem_config_en;
  logic [31:0]   mem_config_addr;
  logic [31:0]   mem_config_data;
  logic          mem_wen;
  logic [DW-1:0] mem_data_in;
  logic          mem_flush;
  logic [DW-1:0] mem_data_out;
  logic          mem_valid_out;

  modport master (
    input  pix_valid, pix_data, mem_data_out, mem_valid_out,
    output pix_ready, mem_config_en, mem_config_addr, mem_config_data,
           mem_wen, mem_data_in, mem_flush
  );

  modport slave (
    output pix_valid, pix_data, mem_data_out, mem_valid_out,
    input  pix_ready, mem_config_en, mem_config_addr, mem_config_data,
           mem_wen, mem_data_in, mem_flush
  );
endinterface

// File: rtl/lb_frame_sequencer.sv
// Frame-level controller for one memory core used as a line buffer: config write, pixel stream, flush.
// Optional LB_SEQ_BACKPRESSURE_EN adds out_ready_i, which stalls pixel intake when low.
//
// state  | meaning
// IDLE   | waiting for a valid start
// CONFIG | one-cycle line-buffer config strobe to the core
// SETTLE | one idle cycle before streaming
// STREAM | accepting pixels, counting columns/rows
// DRAIN  | last pixel visible on mem_wen
// FLUSH  | mem_flush held for FLUSH_CYC cycles
// DONE   | one-cycle done pulse
module lb_frame_sequencer #(
  parameter int DW        = 16,
  parameter int DEPTH_W   = 13,
  parameter int ROW_W     = 16,
  parameter int FLUSH_CYC = 5
) (
  input  logic               clk_in_i,
  input  logic               reset_i,
  input  logic               clk_en_i,
  input  logic               start_i,
  input  logic [DEPTH_W-1:0] cfg_depth_i,
  input  logic [ROW_W-1:0]   cfg_rows_i,
`ifdef LB_SEQ_BACKPRESSURE_EN
  input  logic               out_ready_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic               mem_clk_en_o,
  output logic [DW-1:0]      out_data_o,
  output logic               out_valid_o,
  lb_frame_sequencer_if.master bus
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [DEPTH_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic               wen_q, wen_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      odata_q, odata_d;
  logic               ovalid_q, ovalid_d;

  logic intake_ok;
  logic pix_ready;
  logic accept;
  logic col_last;
  logic row_last;

`ifdef LB_SEQ_BACKPRESSURE_EN
  assign intake_ok = out_ready_i;
`else
  assign intake_ok = 1'b1;
`endif

  assign pix_ready = (state_q == S_STREAM) && clk_en_i && intake_ok;
  assign accept    = pix_ready && bus.pix_valid;
  assign col_last  = (col_q == depth_q - DEPTH_W'(1));
  assign row_last  = (row_q == rows_q - ROW_W'(1));

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    rows_d      = rows_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_cnt_d = flush_cnt_q;
    wen_d       = accept;
    wdata_d     = accept ? bus.pix_data : wdata_q;
    odata_d     = bus.mem_data_out;
    ovalid_d    = bus.mem_valid_out;

    case (state_q)
      S_IDLE: begin
        if (start_i && (cfg_depth_i != '0) && (cfg_rows_i != '0)) begin
          depth_d = cfg_depth_i;
          rows_d  = cfg_rows_i;
          col_d   = '0;
          row_d   = '0;
          state_d = S_CONFIG;
        end
      end
      S_CONFIG: state_d = S_SETTLE;
      S_SETTLE: state_d = S_STREAM;
      S_STREAM: begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + DEPTH_W'(1);
          end
        end
      end
      S_DRAIN: begin
        flush_cnt_d = FW'(FLUSH_CYC - 1);
        state_d     = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over clk_en so a frozen sequencer can still be recovered.
  always_ff @(posedge clk_in_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      rows_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      rows_q      <= rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_cnt_q <= flush_cnt_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
    end
  end

  assign bus.pix_ready       = pix_ready;
  assign bus.mem_config_en   = (state_q == S_CONFIG);
  assign bus.mem_config_addr = 32'h0;
  // Core config word: depth in [DEPTH_W+2:3], enable bit at [2], low two bits zero.
  assign bus.mem_config_data = 32'({depth_q, 3'b100});
  assign bus.mem_wen         = wen_q;
  assign bus.mem_data_in     = wdata_q;
  assign bus.mem_flush       = (state_q == S_FLUSH);

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign mem_clk_en_o = clk_en_i;
  assign out_data_o   = odata_q;
  assign out_valid_o  = ovalid_q;

endmodule

// File: tb/tb_lb_frame_sequencer.sv
// Self-checking bench for lb_frame_sequencer: vector table, directed corner sequences, random frames.
// Reference model tracks a frame as a timeline of enabled cycles since start and beats accepted.
module tb_lb_frame_sequencer;
  localparam int DW      = 16;
  localparam int DEPTH_W = 13;
  localparam int ROW_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               clk_en;
  logic               start;
  logic [DEPTH_W-1:0] cfg_depth;
  logic [ROW_W-1:0]   cfg_rows;
  logic               busy;
  logic               done;
  logic               mem_clk_en;
  logic [DW-1:0]      out_data;
  logic               out_valid;
`ifdef LB_SEQ_BACKPRESSURE_EN
  logic               out_ready;
`endif

  lb_frame_sequencer_if #(.DW(DW)) bus ();

  lb_frame_sequencer #(
    .DW(DW), .DEPTH_W(DEPTH_W), .ROW_W(ROW_W), .FLUSH_CYC(5)
  ) dut (
    .clk_in_i    (clk),
    .reset_i     (reset),
    .clk_en_i    (clk_en),
    .start_i     (start),
    .cfg_depth_i (cfg_depth),
    .cfg_rows_i  (cfg_rows),
`ifdef LB_SEQ_BACKPRESSURE_EN
    .out_ready_i (out_ready),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .mem_clk_en_o(mem_clk_en),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .bus         (bus)
  );

  int checks   = 0;
  int failures = 0;

  // model: m_k = enabled edges since start accepted, m_kL = m_k at the last accept
  bit            m_active;
  int            m_k, m_kL, m_beats, m_N, m_depth;
  logic          m_wen, m_ovalid;
  logic [DW-1:0] m_wdata, m_odata;

  int            n_cfg, n_done, n_wen, src_next;
  logic [31:0]   cfg_cap;
  logic [DW-1:0] wen_log[$];

  typedef struct {
    int          depth;
    int          rows;
    int          vmode;
    bit          acc;
    logic [31:0] cfg;
    int          beats;
  } vec_t;
  vec_t vec[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit seq_ok(input int n);
    if (wen_log.size() != n) return 1'b0;
    foreach (wen_log[i]) if (wen_log[i] !== DW'(i + 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_active = 0; m_k = 0; m_kL = -1; m_beats = 0; m_N = 0; m_depth = 0;
    m_wen = 0; m_wdata = '0; m_odata = '0; m_ovalid = 0;
  endtask

  task automatic tick();
    bit e_ready, acc, e_cfg, e_flush, e_done, gate;
    logic s_reset, s_en, s_start;
    int s_depth, s_rows;
    logic [DW-1:0] s_pdata, s_mdo;
    logic s_mvo;
    bus.mem_data_out  = DW'($urandom);
    bus.mem_valid_out = 1'($urandom_range(0, 1));
    #1;
`ifdef LB_SEQ_BACKPRESSURE_EN
    gate = out_ready;
`else
    gate = 1'b1;
`endif
    e_ready = m_active && m_k >= 3 && m_beats < m_N && clk_en && gate;
    chk("pix_ready", bus.pix_ready, e_ready);
    chk("mem_clk_en", mem_clk_en, clk_en);
    acc = e_ready && bus.pix_valid;
    s_reset = reset; s_en = clk_en; s_start = start;
    s_depth = int'(cfg_depth); s_rows = int'(cfg_rows);
    s_pdata = bus.pix_data; s_mdo = bus.mem_data_out; s_mvo = bus.mem_valid_out;
    @(posedge clk);
    #1;
    if (s_reset) begin
      model_clear();
    end else if (s_en) begin
      m_odata  = s_mdo;
      m_ovalid = s_mvo;
      m_wen    = acc;
      if (acc) begin
        m_wdata = s_pdata;
        src_next++;
      end
      if (m_active) begin
        m_k++;
        if (acc) begin
          m_beats++;
          if (m_beats == m_N) m_kL = m_k;
        end
        if (m_kL >= 0 && m_k == m_kL + 7) m_active = 0;
      end else if (s_start && s_depth != 0 && s_rows != 0) begin
        m_active = 1; m_k = 1; m_kL = -1; m_beats = 0;
        m_N = s_depth * s_rows; m_depth = s_depth;
      end
    end
    e_cfg   = m_active && m_k == 1;
    e_flush = m_active && m_kL >= 0 && m_k >= m_kL + 1 && m_k <= m_kL + 5;
    e_done  = m_active && m_kL >= 0 && m_k == m_kL + 6;
    chk("busy", busy, m_active);
    chk("config_en", bus.mem_config_en, e_cfg);
    if (e_cfg) begin
      chk("config_data", bus.mem_config_data, 64'(m_depth * 8 + 4));
      chk("config_addr", bus.mem_config_addr, 0);
    end
    chk("flush", bus.mem_flush, e_flush);
    chk("done", done, e_done);
    chk("wen", bus.mem_wen, m_wen);
    chk("wdata", bus.mem_data_in, m_wdata);
    chk("out_valid", out_valid, m_ovalid);
    chk("out_data", out_data, m_odata);
    if (s_en && !s_reset) begin
      if (bus.mem_config_en === 1'b1) begin
        n_cfg++;
        cfg_cap = bus.mem_config_data;
      end
      if (done === 1'b1) n_done++;
      if (bus.mem_wen === 1'b1) begin
        n_wen++;
        wen_log.push_back(bus.mem_data_in);
      end
    end
  endtask

  task automatic start_frame(input int depth, input int rows);
    n_cfg = 0; n_done = 0; n_wen = 0; cfg_cap = '0; wen_log.delete(); src_next = 1;
    cfg_depth = DEPTH_W'(depth);
    cfg_rows  = ROW_W'(rows);
    start = 1'b1;
    bus.pix_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // vmode: 0 valid held, 1 alternating, 2 random valid/data/clk_en, 3 start held while busy
  task automatic run_until_idle(input int vmode, input int budget, input int alt_depth);
    bit tog = 1'b0;
    for (int c = 0; c < budget && m_active; c++) begin
      case (vmode)
        0: begin bus.pix_valid = 1'b1; bus.pix_data = DW'(src_next); end
        1: begin bus.pix_valid = tog; tog = !tog; bus.pix_data = DW'(src_next); end
        2: begin
          bus.pix_valid = 1'($urandom_range(0, 1));
          bus.pix_data  = DW'($urandom);
          clk_en        = ($urandom_range(0, 4) != 0);
`ifdef LB_SEQ_BACKPRESSURE_EN
          out_ready     = ($urandom_range(0, 3) != 0);
`endif
        end
        default: begin
          bus.pix_valid = 1'b1; bus.pix_data = DW'(src_next);
          start = 1'b1; cfg_depth = DEPTH_W'(alt_depth);
        end
      endcase
      tick();
    end
    start = 1'b0; clk_en = 1'b1; bus.pix_valid = 1'b0;
`ifdef LB_SEQ_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    chk("frame_timeout", m_active, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{15, 4, 0, 1'b1, 32'h0000_007C, 60};
    vec[1] = '{15, 4, 1, 1'b1, 32'h0000_007C, 60};
    vec[2] = '{1,  1, 0, 1'b1, 32'h0000_000C, 1};
    vec[3] = '{0,  4, 0, 1'b0, 32'h0000_0000, 0};
    vec[4] = '{3,  0, 0, 1'b0, 32'h0000_0000, 0};
    vec[5] = '{5,  3, 1, 1'b1, 32'h0000_002C, 15};
    vec[6] = '{4,  3, 3, 1'b1, 32'h0000_0024, 12};
    vec[7] = '{1,  5, 0, 1'b1, 32'h0000_000C, 5};

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; cfg_depth = '0; cfg_rows = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.mem_data_out = '0; bus.mem_valid_out = 1'b0;
`ifdef LB_SEQ_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    n_cfg = 0; n_done = 0; n_wen = 0; cfg_cap = '0; src_next = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      start_frame(vec[i].depth, vec[i].rows);
      run_until_idle(vec[i].vmode, 2000, vec[i].depth + 3);
      repeat (2) tick();
      chk("vec_cfg_count", n_cfg, vec[i].acc ? 1 : 0);
      chk("vec_cfg_data", cfg_cap, vec[i].cfg);
      chk("vec_beats", n_wen, vec[i].beats);
      chk("vec_done_count", n_done, vec[i].acc ? 1 : 0);
      chk("vec_order", seq_ok(vec[i].beats), 1);
    end

    // reset landing on the second flush cycle
    start_frame(15, 4);
    for (int c = 0; c < 400 && !(m_kL >= 0 && m_k == m_kL + 2); c++) begin
      bus.pix_valid = 1'b1; bus.pix_data = DW'(src_next);
      tick();
    end
    bus.pix_valid = 1'b0;
    chk("flush_before_reset", bus.mem_flush, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_flush", bus.mem_flush, 0);
    chk("rst_busy", busy, 0);
    repeat (4) tick();
    chk("rst_no_done", n_done, 0);
    start_frame(15, 4);
    run_until_idle(0, 2000, 0);
    repeat (2) tick();
    chk("post_rst_cfg", cfg_cap, 32'h0000_007C);
    chk("post_rst_beats", n_wen, 60);
    chk("post_rst_done", n_done, 1);

    // clk_en low for 5 cycles mid-stream
    start_frame(15, 4);
    for (int c = 0; c < 400 && m_beats < 20; c++) begin
      bus.pix_valid = 1'b1; bus.pix_data = DW'(src_next);
      tick();
    end
    clk_en = 1'b0;
    repeat (5) tick();
    chk("stall_beats_held", n_wen, 20);
    clk_en = 1'b1;
    run_until_idle(0, 2000, 0);
    repeat (2) tick();
    chk("stall_beats", n_wen, 60);
    chk("stall_order", seq_ok(60), 1);
    chk("stall_done", n_done, 1);

`ifdef LB_SEQ_BACKPRESSURE_EN
    start_frame(4, 2);
    for (int c = 0; c < 50 && m_k < 4; c++) begin
      bus.pix_valid = 1'b1; bus.pix_data = DW'(src_next);
      tick();
    end
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    run_until_idle(0, 500, 0);
    repeat (2) tick();
    chk("bp_beats", n_wen, 8);
    chk("bp_order", seq_ok(8), 1);
`endif

    for (int r = 0; r < 8; r++) begin
      int d, rw;
      d  = $urandom_range(1, 7);
      rw = $urandom_range(1, 4);
      start_frame(d, rw);
      run_until_idle(2, 3000, 0);
      repeat (2) tick();
      chk("rnd_beats", n_wen, d * rw);
      chk("rnd_done", n_done, 1);
      chk("rnd_cfg", cfg_cap, 64'(d * 8 + 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
